aes_dec_key_sched: RTL and testbench

Decrypt-side round-key generator that sits directly upstream of the decrypt round chain.
- Accepts a 128-bit AES cipher key and runs forward key expansion, one round key per cycle.
- Stores all NR+1 round keys, then hands them out in reverse order (rk[NR] down to rk[0]) on a valid/req handshake.
- Order of use: rk[NR] feeds the initial AddRoundKey round, rk[NR-1..1] the middle rounds, rk[0] the final round.

---
 rtl/aes_pkg.sv | 69 ++++++
 rtl/aes_key_expand_step.sv | 34 +++
 rtl/aes_dec_key_sched.sv | 151 +++++++++++++++
 tb/tb_aes_dec_key_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES key schedule.
// Used by aes_key_expand_step and aes_dec_key_sched.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] rk_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ks_state_t;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // Inverse as x^254 via an add-one/square chain; 0 maps to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] v;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        v = gf_mul(r, r);
        return v
             ^ {v[6:0], v[7]}
             ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 forward key-expansion round: next round key from previous.
// Purely combinational; four S-box lookups on RotWord(w3).
module aes_key_expand_step
    import aes_pkg::*;
(
    input  rk_t        prev_key,
    input  logic [7:0] rcon,
    output rk_t        next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    assign rot = {w3[23:0], w3[31:24]};

    assign sub = {sbox(rot[31:24]),
                  sbox(rot[23:16]),
                  sbox(rot[15:8]),
                  sbox(rot[7:0])};

    assign n0 = w0 ^ sub ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_dec_key_sched.sv
// Decrypt-side round-key generator: expands, stores, serves rk[10]..rk[0].
// Optional AES_KEYSCHED_REPLAY_EN: replay stored keys without re-expansion.
module aes_dec_key_sched
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] key_in,
    input  logic          key_valid,
    input  logic          rk_req,
`ifdef AES_KEYSCHED_REPLAY_EN
    input  logic          replay,
`endif
    output logic [DW-1:0] rk_out,
    output logic [3:0]    rk_idx,
    output logic          rk_valid,
    output logic          busy,
    output logic          done
);

    if (NR != AES_NR || DW != 128) begin : g_bad_cfg
        $error("aes_dec_key_sched: only NR=10, DW=128 supported");
    end

    localparam logic [3:0] LAST = 4'(NR);

    ks_state_t  state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [3:0] ptr, ptr_d;
    rk_t        rk_mem [0:NR];
    rk_t        prev_key, next_key, out_d;
    logic       load, exp_we, done_d;
`ifdef AES_KEYSCHED_REPLAY_EN
    logic       keys_loaded, kl_d;
`endif

    assign prev_key = rk_mem[cnt - 4'd1];

    aes_key_expand_step u_step (
        .prev_key (prev_key),
        .rcon     (rcon_of(cnt)),
        .next_key (next_key)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ptr_d   = ptr;
        out_d   = rk_out;
        load    = 1'b0;
        exp_we  = 1'b0;
        done_d  = 1'b0;
`ifdef AES_KEYSCHED_REPLAY_EN
        kl_d    = keys_loaded;
`endif
        unique case (state)
            IDLE: begin
                if (key_valid) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                    cnt_d   = 4'd1;
`ifdef AES_KEYSCHED_REPLAY_EN
                    kl_d    = 1'b0;
                end else if (replay && keys_loaded) begin
                    state_d = READY;
                    ptr_d   = LAST;
                    out_d   = rk_mem[LAST];
`endif
                end
            end
            EXPAND: begin
                exp_we = 1'b1;
                if (cnt == LAST) begin
                    state_d = READY;
                    cnt_d   = 4'd0;
                    ptr_d   = LAST;
                    out_d   = next_key;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            READY: begin
                if (key_valid) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                    cnt_d   = 4'd1;
                    ptr_d   = 4'd0;
                    out_d   = '0;
                    done_d  = rk_req && (ptr == 4'd0);
`ifdef AES_KEYSCHED_REPLAY_EN
                    kl_d    = 1'b0;
`endif
                end else if (rk_req) begin
                    if (ptr == 4'd0) begin
                        state_d = IDLE;
                        out_d   = '0;
                        done_d  = 1'b1;
`ifdef AES_KEYSCHED_REPLAY_EN
                        kl_d    = 1'b1;
`endif
                    end else begin
                        ptr_d = ptr - 4'd1;
                        out_d = rk_mem[ptr - 4'd1];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                ptr_d   = 4'd0;
                out_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ptr      <= 4'd0;
            rk_out   <= '0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                rk_mem[i] <= '0;
            end
`ifdef AES_KEYSCHED_REPLAY_EN
            keys_loaded <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            ptr      <= ptr_d;
            rk_out   <= out_d;
            rk_valid <= (state_d == READY);
            done     <= done_d;
            if (load)   rk_mem[0]   <= key_in;
            if (exp_we) rk_mem[cnt] <= next_key;
`ifdef AES_KEYSCHED_REPLAY_EN
            keys_loaded <= kl_d;
`endif
        end
    end

    assign rk_idx = ptr;
    assign busy   = (state == EXPAND);

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Self-checking bench for aes_dec_key_sched against a word-level
// FIPS-197 key-expansion model (S-box built by brute-force inversion).
module tb_aes_dec_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         rk_req = 1'b0;
    logic         replay = 1'b0;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         busy;
    logic         done;

    aes_dec_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .rk_req    (rk_req),
`ifdef AES_KEYSCHED_REPLAY_EN
        .replay    (replay),
`endif
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    int tests = 0;
    int fails = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] ref_rk [11];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 8'h00) begin
            if (y[0]) p ^= x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int k = 1; k < 256; k++) begin
                if (gmul(8'(x), 8'(k)) == 8'h01) inv = 8'(k);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            sbox_t[x] = s;
        end
    endtask

    task automatic build_ref(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]],
                     sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            ref_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    // Waits for rk_valid; optionally pulses key_valid at edge number inj.
    task automatic wait_valid(input int inj, input logic [127:0] other,
                              output int n, output int dones);
        n = 0;
        dones = 0;
        while (!rk_valid && n < 40) begin
            if (n == inj) begin
                key_in    = other;
                key_valid = 1'b1;
            end
            step();
            key_valid = 1'b0;
            if (done) dones++;
            n++;
        end
    endtask

    task automatic readout_to(input string tag, input int stop);
        rk_req = 1'b1;
        for (int i = 10; i > stop; i--) begin
            chk({tag, "_valid"}, 128'(rk_valid), 128'(1));
            chk({tag, "_idx"}, 128'(rk_idx), 128'(i));
            chk({tag, "_out"}, rk_out, ref_rk[i]);
            step();
        end
        rk_req = 1'b0;
    endtask

    task automatic readout_full(input string tag);
        readout_to(tag, 0);
        chk({tag, "_idx0"}, 128'(rk_idx), 128'(0));
        chk({tag, "_out0"}, rk_out, ref_rk[0]);
        rk_req = 1'b1;
        step();
        rk_req = 1'b0;
        chk({tag, "_done"}, 128'(done), 128'(1));
        chk({tag, "_vdrop"}, 128'(rk_valid), 128'(0));
        step();
        chk({tag, "_done_once"}, 128'(done), 128'(0));
    endtask

    int n, dn, exp_i, cyc, r;
    logic [127:0] rnd_key;

    initial begin
        init_sbox();

        #3;
        chk("rst_out", rk_out, 128'(0));
        chk("rst_idx", 128'(rk_idx), 128'(0));
        chk("rst_valid", 128'(rk_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        #9 rst_n = 1'b1;
        step();

        // A: FIPS key, rk_req held high
        build_ref(FIPS_KEY);
        rk_req = 1'b1;
        load_key(FIPS_KEY);
        chk("a_busy", 128'(busy), 128'(1));
        chk("a_valid_lo", 128'(rk_valid), 128'(0));
        wait_valid(-1, '0, n, dn);
        chk("a_latency", 128'(n + 1), 128'(11));
        chk("a_busy_lo", 128'(busy), 128'(0));
        chk("a_rk10_vec", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        readout_full("a");
        chk("a_rk0_key", ref_rk[0], FIPS_KEY);

        // B: same key, random rk_req
        load_key(FIPS_KEY);
        wait_valid(-1, '0, n, dn);
        exp_i = 10;
        cyc = 0;
        while (exp_i >= 0 && cyc < 400) begin
            chk("b_valid", 128'(rk_valid), 128'(1));
            chk("b_idx", 128'(rk_idx), 128'(exp_i));
            chk("b_out", rk_out, ref_rk[exp_i]);
            if (exp_i == 9) chk("b_rk9_vec", rk_out, 128'hac7766f319fadc2128d12941575c006e);
            r = int'($urandom_range(0, 1));
            rk_req = r[0];
            step();
            rk_req = 1'b0;
            if (r != 0) exp_i--;
            cyc++;
        end
        chk("b_bound", 128'(exp_i), 128'(-1));
        chk("b_done", 128'(done), 128'(1));
        step();

        // C: key_valid during EXPAND cycle 5 is ignored
        rnd_key = {$urandom, $urandom, $urandom, $urandom};
        load_key(FIPS_KEY);
        wait_valid(4, rnd_key, n, dn);
        chk("c_latency", 128'(n), 128'(10));
        readout_full("c");

        // D: abort at idx 6 with SEQ_KEY
        load_key(FIPS_KEY);
        wait_valid(-1, '0, n, dn);
        readout_to("d_pre", 6);
        build_ref(SEQ_KEY);
        rk_req = 1'b1;
        load_key(SEQ_KEY);
        rk_req = 1'b0;
        chk("d_vdrop", 128'(rk_valid), 128'(0));
        chk("d_busy", 128'(busy), 128'(1));
        chk("d_nodone", 128'(done), 128'(0));
        wait_valid(-1, '0, n, dn);
        chk("d_latency", 128'(n), 128'(10));
        chk("d_nodone_exp", 128'(dn), 128'(0));
        chk("d_rk10_vec", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        readout_to("d", 0);

        // E: key_valid coinciding with the ptr=0 consume
        rk_req = 1'b1;
        load_key(FIPS_KEY);
        rk_req = 1'b0;
        chk("e_done", 128'(done), 128'(1));
        chk("e_busy", 128'(busy), 128'(1));
        chk("e_vdrop", 128'(rk_valid), 128'(0));
        build_ref(FIPS_KEY);
        wait_valid(-1, '0, n, dn);
        chk("e_latency", 128'(n), 128'(10));
        readout_to("e", 4);

        // F: asynchronous reset mid-readout at idx 4
        #3 rst_n = 1'b0;
        #1;
        chk("f_out", rk_out, 128'(0));
        chk("f_idx", 128'(rk_idx), 128'(0));
        chk("f_valid", 128'(rk_valid), 128'(0));
        chk("f_busy", 128'(busy), 128'(0));
        chk("f_done", 128'(done), 128'(0));
        #3 rst_n = 1'b1;
        rk_req = 1'b1;
        replay = 1'b1;
        step();
        step();
        replay = 1'b0;
        rk_req = 1'b0;
        chk("f_idle_valid", 128'(rk_valid), 128'(0));
        chk("f_idle_busy", 128'(busy), 128'(0));

        // G: random keys
        for (int k = 0; k < 3; k++) begin
            rnd_key = {$urandom, $urandom, $urandom, $urandom};
            build_ref(rnd_key);
            load_key(rnd_key);
            wait_valid(-1, '0, n, dn);
            chk("g_latency", 128'(n), 128'(10));
            readout_full("g");
        end

`ifdef AES_KEYSCHED_REPLAY_EN
        // H: replay stored keys without re-expansion
        build_ref(FIPS_KEY);
        load_key(FIPS_KEY);
        wait_valid(-1, '0, n, dn);
        readout_full("h_first");
        replay = 1'b1;
        step();
        replay = 1'b0;
        chk("h_valid", 128'(rk_valid), 128'(1));
        chk("h_idx", 128'(rk_idx), 128'(10));
        chk("h_busy", 128'(busy), 128'(0));
        chk("h_rk10_vec", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        readout_full("h");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
